pc_gen_ras: RTL
===============

Name: pc_gen_ras

Overview:
- Parametrised next-generation fetch program counter.
- Produces the instruction fetch address and valid strobe for the instruction memory.
- Supports a stall enable and three redirect sources with fixed priority: exception, return, branch/jump.
- Contains an internal return-address stack (RAS) so call/return redirects need no target from the decoder.
- Sits at the head of the fetch stage and replaces the single-mode counter.

Parameters:
- PC_WIDTH, 32, width of every address in the block.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two, ≥2.
- RAS_PTR_W, 2, log2(RAS_DEPTH).

Ports:
- pcg_clk  in  1  clock; all state on rising edge.
- pcg_rst  in  1  reset; asynchronous, active-low.
- pcg_i_ce  in  1  advance enable; 0 = stall, all state holds.
- pcg_i_exc  in  1  exception redirect request.
- pcg_i_exc_vec  in  PC_WIDTH  exception target.
- pcg_i_change_pc  in  1  branch/jump redirect request.
- pcg_i_pc  in  PC_WIDTH  branch/jump target; also the fallback target on RAS underflow.
- pcg_i_call  in  1  qualifies change_pc as a call; pushes pcg_i_link.
- pcg_i_link  in  PC_WIDTH  return address to push.
- pcg_i_ret  in  1  return redirect; target is the RAS top.
- pcg_o_pc  out  PC_WIDTH  fetch address.
- pcg_o_ce  out  1  fetch address valid.
- pcg_o_ras_empty  out  1  RAS count == 0.
- pcg_o_ras_full  out  1  RAS count == RAS_DEPTH.
- pcg_o_ras_err  out  1  one-cycle pulse on underflow pop.

Behaviour:
- Reset (async, pcg_rst=0):
  - pcg_o_pc=0, pcg_o_ce=0, pcg_o_ras_err=0.
  - Internal next-PC register npc=RESET_PC.
  - RAS count=0, top pointer=0; entry contents don't-care.
  - empty=1, full=0.
- Reset assertion mid-operation discards all state immediately, including RAS contents. Release is synchronous to pcg_clk in the surrounding design.
- Two-register structure. On each rising edge with pcg_i_ce=1:
  - pcg_o_pc<=npc, pcg_o_ce<=1.
  - npc<=selected next value.
  - So a redirect target appears on pcg_o_pc on the second ce edge after the request; the already-prefetched sequential PC is emitted first. This one-slot delay is intentional; downstream squashes it.
- pcg_i_ce=0: no register changes. Redirect, call and ret inputs are ignored. Requesters hold them until ce=1.
- npc selection when ce=1, highest priority first:
  - exc -> pcg_i_exc_vec.
  - ret -> RAS top if count>0, else pcg_i_pc.
  - change_pc -> pcg_i_pc.
  - otherwise -> npc+PC_STEP, modulo 2^PC_WIDTH (wraps to 0, no flag).
- RAS operations occur only when ce=1 and exc=0. exc suppresses push and pop; RAS is untouched.
- Push: condition change_pc & call & ~ret.
  - ptr<=ptr+1 (mod depth); entry[ptr+1]<=pcg_i_link.
  - count<=min(count+1, RAS_DEPTH).
  - When full, the oldest entry is overwritten silently; count stays RAS_DEPTH.
- Pop: condition ret & ~call.
  - If count>0: ptr<=ptr-1, count<=count-1.
  - If count=0: no pointer change; pcg_o_ras_err=1 for exactly one cycle.
- ret & call together (tail call): target is the current top (or pcg_i_pc if empty, with err pulse). The top entry is replaced by pcg_i_link; count=max(count,1), ptr unchanged if count>0. If count was 0, ptr increments and count becomes 1.
- call without change_pc: ignored.
- ret with change_pc: ret wins.
- Flags are registered and consistent with count after each edge.
- Implementation target ~200 lines.

Test Plan:
- Reset release, ce=1 continuously, RESET_PC=0x100 -> o_pc 0x100, 0x104, 0x108 with o_ce=1 from the first edge. Hold ce=0 for 3 cycles -> o_pc frozen at its current value.
- change_pc=1, pc=0x2000 for one ce edge while npc=0x10C -> o_pc 0x10C, then 0x2000, then 0x2004.
- call with link=0x110 to 0x3000, then ret -> after ret, o_pc sequence reaches 0x110. Empty goes 1→0→1.
- Five calls, RAS_DEPTH=4, links A..E, then five rets -> returns E, D, C, B. Fifth ret redirects to pcg_i_pc with ras_err pulsing exactly one cycle. full=1 after the fourth call.
- exc=1, vec=0x80, ret=1 and change_pc=1 on the same edge -> target 0x80; RAS count unchanged.
- Async reset asserted mid-sequence with RAS count=3 -> o_pc=0, o_ce=0, empty=1 immediately, without waiting for a clock edge.
- npc=0xFFFFFFFC, sequential advance -> next o_pc wraps to 0x00000000.

Source files
------------

// File: rtl/pc_gen_ras.sv
// Fetch program counter with stall, prioritised redirects (exception > return > branch)
// and an internal return-address stack that supplies return targets on its own.
module pc_gen_ras #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  PC_STEP   = 4,
    parameter int                  RAS_DEPTH = 4,
    parameter int                  RAS_PTR_W = 2
) (
    input  logic                pcg_clk,
    input  logic                pcg_rst,
    input  logic                pcg_i_ce,
    input  logic                pcg_i_exc,
    input  logic [PC_WIDTH-1:0] pcg_i_exc_vec,
    input  logic                pcg_i_change_pc,
    input  logic [PC_WIDTH-1:0] pcg_i_pc,
    input  logic                pcg_i_call,
    input  logic [PC_WIDTH-1:0] pcg_i_link,
    input  logic                pcg_i_ret,
    output logic [PC_WIDTH-1:0] pcg_o_pc,
    output logic                pcg_o_ce,
    output logic                pcg_o_ras_empty,
    output logic                pcg_o_ras_full,
    output logic                pcg_o_ras_err
);

    localparam logic [PC_WIDTH-1:0]  STEP     = PC_WIDTH'(PC_STEP);
    localparam logic [RAS_PTR_W:0]   CNT_FULL = (RAS_PTR_W+1)'(RAS_DEPTH);
    localparam logic [RAS_PTR_W:0]   CNT_ONE  = (RAS_PTR_W+1)'(1);
    localparam logic [RAS_PTR_W-1:0] PTR_ONE  = RAS_PTR_W'(1);

    // Enable semantics: pcg_i_ce=1 advances every register on the edge; with
    // pcg_i_ce=0 all state holds and redirect/call/ret requests are not consumed,
    // so requesters keep them asserted until an edge with pcg_i_ce=1.

    logic [PC_WIDTH-1:0]  pc_q, npc_q, npc_d;
    logic                 ce_q, err_q;
    logic [PC_WIDTH-1:0]  ras_mem [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ptr_q, ptr_d, wr_idx;
    logic [RAS_PTR_W:0]   cnt_q, cnt_d;
    logic                 wr_en, underflow, have_top, is_full;
    logic [PC_WIDTH-1:0]  top;

    assign have_top = (cnt_q != '0);
    assign is_full  = (cnt_q == CNT_FULL);
    assign top      = ras_mem[ptr_q];

    always_comb begin
        npc_d     = npc_q + STEP;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        wr_idx    = ptr_q;
        underflow = 1'b0;
        if (pcg_i_exc) begin
            npc_d = pcg_i_exc_vec;
        end else if (pcg_i_ret) begin
            npc_d     = have_top ? top : pcg_i_pc;
            underflow = ~have_top;
            if (pcg_i_call) begin
                // Tail call: the link replaces the top, or becomes the only entry.
                wr_en = 1'b1;
                if (!have_top) begin
                    ptr_d  = ptr_q + PTR_ONE;
                    wr_idx = ptr_q + PTR_ONE;
                    cnt_d  = CNT_ONE;
                end
            end else if (have_top) begin
                ptr_d = ptr_q - PTR_ONE;
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (pcg_i_change_pc) begin
            npc_d = pcg_i_pc;
            if (pcg_i_call) begin
                // A full stack wraps the pointer onto the oldest entry.
                wr_en  = 1'b1;
                ptr_d  = ptr_q + PTR_ONE;
                wr_idx = ptr_q + PTR_ONE;
                cnt_d  = is_full ? cnt_q : cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge pcg_clk or negedge pcg_rst) begin
        if (!pcg_rst) begin
            pc_q  <= '0;
            ce_q  <= 1'b0;
            npc_q <= RESET_PC;
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (pcg_i_ce) begin
            pc_q  <= npc_q;
            ce_q  <= 1'b1;
            npc_q <= npc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= underflow;
        end else begin
            // The error strobe is a single-cycle pulse even across a stall.
            err_q <= 1'b0;
        end
    end

    always_ff @(posedge pcg_clk) begin
        if (pcg_i_ce && wr_en) begin
            ras_mem[wr_idx] <= pcg_i_link;
        end
    end

    assign pcg_o_pc        = pc_q;
    assign pcg_o_ce        = ce_q;
    assign pcg_o_ras_empty = ~have_top;
    assign pcg_o_ras_full  = is_full;
    assign pcg_o_ras_err   = err_q;

endmodule
